// File: rtl/lift_bank_arbiter_if.sv
// Lift-to-bank bus: lift request/response handshake plus the shared bank bus.
// The master side is the lift unit together with the bank memories; the slave side is the arbiter.
interface lift_bank_arbiter_if #(
  parameter int NUM_PROC = 7,
  parameter int DW       = 240,
  parameter int AW       = 9
);
  logic                     lift_req;
  logic [2:0]               processor_sel;
  logic [3:0]               memory_sel;
  logic [AW-1:0]            bram_address;
  logic                     bram_we;
  logic [DW-1:0]            lift_data_out;
  logic                     lift_stall;
  logic [DW-1:0]            lift_data_in;
  logic                     lift_rvalid;
  logic [NUM_PROC-1:0]      proc_busy;
  logic [NUM_PROC-1:0]      bank_en;
  logic [NUM_PROC-1:0]      bank_we;
  logic [3:0]               bank_mem_sel;
  logic [AW-1:0]            bank_addr;
  logic [DW-1:0]            bank_wdata;
  logic [NUM_PROC*DW-1:0]   bank_rdata;

  modport master (
    output lift_req, processor_sel, memory_sel, bram_address, bram_we, lift_data_out,
    output proc_busy, bank_rdata,
    input  lift_stall, lift_data_in, lift_rvalid,
    input  bank_en, bank_we, bank_mem_sel, bank_addr, bank_wdata
  );

  modport slave (
    input  lift_req, processor_sel, memory_sel, bram_address, bram_we, lift_data_out,
    input  proc_busy, bank_rdata,
    output lift_stall, lift_data_in, lift_rvalid,
    output bank_en, bank_we, bank_mem_sel, bank_addr, bank_wdata
  );
endinterface

// File: rtl/lift_bank_arbiter.sv
// Routes lift BRAM requests to per-processor coefficient banks with a fixed 2-cycle read latency.
// Optional LIFT_ARB_BROADCAST_EN: a write to processor_sel 7 is broadcast to every bank.
module lift_bank_arbiter #(
  parameter int NUM_PROC = 7,
  parameter int DW       = 240,
  parameter int AW       = 9
) (
  input  logic                clk,
  input  logic                rst,
  lift_bank_arbiter_if.slave  bus,
  output logic                err_sel,
  output logic [15:0]         stall_count
);

  logic [NUM_PROC-1:0] sel_onehot;
  logic [NUM_PROC-1:0] target;
  logic                sel_legal;
  logic                bcast;
  logic                stall;
  logic                accept;
  logic                issue;
  logic                s1_rd;
  logic                s2_rd;
  logic [2:0]          s1_sel;
  logic [2:0]          s2_sel;

  // Out-of-range selects shift the single one out of the vector, so they never hit proc_busy.
  always_comb begin
    sel_onehot = {{(NUM_PROC-1){1'b0}}, 1'b1} << bus.processor_sel;
    sel_legal  = int'(bus.processor_sel) < NUM_PROC;
`ifdef LIFT_ARB_BROADCAST_EN
    bcast      = (bus.processor_sel == 3'd7) && bus.bram_we;
`else
    bcast      = 1'b0;
`endif
    target     = bcast ? {NUM_PROC{1'b1}} : sel_onehot;
    stall      = bus.lift_req & (bcast ? (|bus.proc_busy) : (|(bus.proc_busy & sel_onehot)));
    accept     = bus.lift_req & ~stall;
    issue      = accept & (sel_legal | bcast);
  end

  assign bus.lift_stall = stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.bank_en      <= '0;
      bus.bank_we      <= '0;
      bus.bank_addr    <= '0;
      bus.bank_mem_sel <= '0;
      bus.bank_wdata   <= '0;
      s1_rd            <= 1'b0;
      s1_sel           <= '0;
    end else begin
      bus.bank_en <= '0;
      bus.bank_we <= '0;
      s1_rd       <= 1'b0;
      if (issue) begin
        bus.bank_en      <= target;
        bus.bank_we      <= bus.bram_we ? target : '0;
        bus.bank_addr    <= bus.bram_address;
        bus.bank_mem_sel <= bus.memory_sel;
        bus.bank_wdata   <= bus.lift_data_out;
        s1_rd            <= ~bus.bram_we;
        s1_sel           <= bus.processor_sel;
      end
    end
  end

  // Bank data is valid one cycle after the strobe, so the slice is captured one stage later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_rd            <= 1'b0;
      s2_sel           <= '0;
      bus.lift_rvalid  <= 1'b0;
      bus.lift_data_in <= '0;
    end else begin
      s2_rd           <= s1_rd;
      s2_sel          <= s1_sel;
      bus.lift_rvalid <= s2_rd;
      if (s2_rd) begin
        bus.lift_data_in <= bus.bank_rdata[s2_sel*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sel     <= 1'b0;
      stall_count <= '0;
    end else begin
      if (accept && !sel_legal && !bcast) begin
        err_sel <= 1'b1;
      end
      if (stall && (stall_count != 16'hFFFF)) begin
        stall_count <= stall_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_lift_bank_arbiter.sv
// Scoreboard bench for lift_bank_arbiter: a driver predicts strobes and read data from a
// word-level memory model; a monitor compares them as the DUT presents them.
module tb_lift_bank_arbiter;
  localparam int NUM_PROC = 7;
  localparam int DW       = 240;
  localparam int AW       = 9;
`ifdef LIFT_ARB_BROADCAST_EN
  localparam bit BCAST = 1'b1;
`else
  localparam bit BCAST = 1'b0;
`endif

  typedef struct {
    logic [NUM_PROC-1:0] en;
    logic [NUM_PROC-1:0] we;
    logic [AW-1:0]       addr;
    logic [3:0]          mem;
    logic [DW-1:0]       wdata;
    logic                err;
    logic [15:0]         cnt;
  } strobe_t;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } read_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        err_sel;
  logic [15:0] stall_count;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;

  lift_bank_arbiter_if #(.NUM_PROC(NUM_PROC), .DW(DW), .AW(AW)) bus ();

  lift_bank_arbiter #(.NUM_PROC(NUM_PROC), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .err_sel(err_sel), .stall_count(stall_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] bank_store [int];
  logic [DW-1:0] ref_store [int];
  strobe_t       strobe_q [$];
  read_t         read_q [$];
  logic [AW-1:0] m_addr;
  logic [3:0]    m_mem;
  logic [DW-1:0] m_wdata;
  logic          m_err;
  logic [15:0]   m_cnt;
  logic [DW-1:0] last_read;
  strobe_t       mon_e;
  read_t         mon_r;

  function automatic int key_of(int b, int m, int a);
    return b * 8192 + m * 512 + a;
  endfunction

  function automatic logic [DW-1:0] init_word(int b, int m, int a);
    logic [DW-1:0] w;
    for (int k = 0; k < 8; k++)
      w[k*30 +: 30] = 30'((b * 131071 + m * 8191 + a * 127 + k * 977) ^ 32'h02A5A5A5);
    return w;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int k = 0; k < 8; k++) d[k*30 +: 30] = 30'($urandom);
    return d;
  endfunction

  // Bank memories: synchronous RAMs, read data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (rst) begin
      bus.bank_rdata <= '0;
    end else begin
      for (int b = 0; b < NUM_PROC; b++) begin
        if (bus.bank_en[b]) begin
          if (bus.bank_we[b])
            bank_store[key_of(b, int'(bus.bank_mem_sel), int'(bus.bank_addr))] = bus.bank_wdata;
          else if (bank_store.exists(key_of(b, int'(bus.bank_mem_sel), int'(bus.bank_addr))))
            bus.bank_rdata[b*DW +: DW] <= bank_store[key_of(b, int'(bus.bank_mem_sel), int'(bus.bank_addr))];
          else
            bus.bank_rdata[b*DW +: DW] <= init_word(b, int'(bus.bank_mem_sel), int'(bus.bank_addr));
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name, input string what);
    checks++;
    errors++;
    $display("[TB] FAIL %s: %s", name, what);
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst = 1'b1;
    bus.lift_req  = 1'b0;
    bus.proc_busy = '0;
    strobe_q.delete();
    read_q.delete();
    m_addr = '0; m_mem = '0; m_wdata = '0; m_err = 1'b0; m_cnt = '0; last_read = '0;
    #1;
    checkOutput("reset bank_en", DW'(bus.bank_en), '0);
    checkOutput("reset bank_we", DW'(bus.bank_we), '0);
    checkOutput("reset bank_addr", DW'(bus.bank_addr), '0);
    checkOutput("reset bank_mem_sel", DW'(bus.bank_mem_sel), '0);
    checkOutput("reset bank_wdata", bus.bank_wdata, '0);
    checkOutput("reset lift_data_in", bus.lift_data_in, '0);
    checkOutput("reset lift_rvalid", DW'(bus.lift_rvalid), '0);
    checkOutput("reset err_sel", DW'(err_sel), '0);
    checkOutput("reset stall_count", DW'(stall_count), '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One request cycle: drive at negedge, predict stall/accept and the resulting bank activity.
  task automatic applyStimulus(input logic r, input logic [2:0] sel, input logic [3:0] mem,
                               input logic [AW-1:0] addr, input logic we, input logic [DW-1:0] wd,
                               input logic [NUM_PROC-1:0] busy, output logic accepted);
    logic    bc, legal, st;
    logic [NUM_PROC-1:0] tgt;
    strobe_t e;
    @(negedge clk);
    bus.lift_req = r; bus.processor_sel = sel; bus.memory_sel = mem;
    bus.bram_address = addr; bus.bram_we = we; bus.lift_data_out = wd; bus.proc_busy = busy;
    #1;
    bc    = BCAST && (sel == 3'd7) && we;
    legal = int'(sel) < NUM_PROC;
    if (bc)         st = r && (busy != '0);
    else if (legal) st = r && (((busy >> sel) & NUM_PROC'(1)) != '0);
    else            st = 1'b0;
    checkOutput("lift_stall", DW'(bus.lift_stall), DW'(st));
    accepted = r && !st;
    e.en = '0;
    e.we = '0;
    if (accepted && (legal || bc)) begin
      tgt = bc ? {NUM_PROC{1'b1}} : (NUM_PROC'(1) << sel);
      e.en = tgt;
      e.we = we ? tgt : '0;
      m_addr = addr; m_mem = mem; m_wdata = wd;
      if (we) begin
        for (int b = 0; b < NUM_PROC; b++)
          if (tgt[b]) ref_store[key_of(b, int'(mem), int'(addr))] = wd;
      end else begin
        read_t rr;
        if (ref_store.exists(key_of(int'(sel), int'(mem), int'(addr))))
          rr.data = ref_store[key_of(int'(sel), int'(mem), int'(addr))];
        else
          rr.data = init_word(int'(sel), int'(mem), int'(addr));
        rr.due = cyc + 3;
        read_q.push_back(rr);
      end
    end else if (accepted) begin
      m_err = 1'b1;
    end
    if (st && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    e.addr = m_addr; e.mem = m_mem; e.wdata = m_wdata; e.err = m_err; e.cnt = m_cnt;
    strobe_q.push_back(e);
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 3'd0, 4'd0, '0, 1'b0, '0, '0, a);
  endtask

  // Monitor: one expected strobe set per driven cycle, read data in order at its due cycle.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (strobe_q.size() > 0) begin
        mon_e = strobe_q.pop_front();
        checkOutput("bank_en", DW'(bus.bank_en), DW'(mon_e.en));
        checkOutput("bank_we", DW'(bus.bank_we), DW'(mon_e.we));
        checkOutput("bank_addr", DW'(bus.bank_addr), DW'(mon_e.addr));
        checkOutput("bank_mem_sel", DW'(bus.bank_mem_sel), DW'(mon_e.mem));
        checkOutput("bank_wdata", bus.bank_wdata, mon_e.wdata);
        checkOutput("err_sel", DW'(err_sel), DW'(mon_e.err));
        checkOutput("stall_count", DW'(stall_count), DW'(mon_e.cnt));
      end
      while (read_q.size() > 0 && read_q[0].due < cyc) begin
        mon_r = read_q.pop_front();
        failNow("lift_rvalid missing", $sformatf("no pulse at cycle %0d", mon_r.due));
      end
      if (bus.lift_rvalid) begin
        if (read_q.size() == 0) begin
          failNow("lift_rvalid unexpected", $sformatf("pulse at cycle %0d", cyc));
        end else begin
          mon_r = read_q.pop_front();
          checkOutput("lift_rvalid timing", DW'(cyc), DW'(mon_r.due));
          checkOutput("lift_data_in", bus.lift_data_in, mon_r.data);
          last_read = mon_r.data;
        end
      end else begin
        checkOutput("lift_data_in hold", bus.lift_data_in, last_read);
      end
    end
  end

  initial begin
    logic          acc;
    logic          r, rw;
    logic [2:0]    rs;
    logic [3:0]    rm;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    logic [DW-1:0] pat;
    bus.lift_req = 1'b0; bus.processor_sel = '0; bus.memory_sel = '0; bus.bram_address = '0;
    bus.bram_we = 1'b0; bus.lift_data_out = '0; bus.proc_busy = '0;
    resetDut();

    $display("[TB] directed read bank 0");
    pat = {8{30'd619584084}};
    bank_store[key_of(0, 0, 1)] = pat;
    ref_store[key_of(0, 0, 1)]  = pat;
    applyStimulus(1'b1, 3'd0, 4'd0, 9'd1, 1'b0, '0, '0, acc);
    idle(3);

    $display("[TB] back-to-back reads across all banks");
    for (int i = 0; i < NUM_PROC; i++)
      applyStimulus(1'b1, 3'(i), 4'(i % 2), AW'((i % 2) ? 3 : 2), 1'b0, '0, '0, acc);
    idle(3);

    $display("[TB] write bank 3 then read back");
    pat = {8{30'd102873779}};
    applyStimulus(1'b1, 3'd3, 4'd2, 9'd40, 1'b1, pat, '0, acc);
    applyStimulus(1'b1, 3'd3, 4'd2, 9'd40, 1'b0, '0, '0, acc);
    idle(3);

    $display("[TB] stall while processor 5 owns its bank");
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 3'd5, 4'd1, 9'd7, 1'b0, '0, 7'b0100000, acc);
    applyStimulus(1'b1, 3'd5, 4'd1, 9'd7, 1'b0, '0, '0, acc);
    @(posedge clk); #2;
    checkOutput("stall_count after busy", DW'(stall_count), DW'(16'd4));
    idle(3);

    $display("[TB] processor_sel 7");
    applyStimulus(1'b1, 3'd7, 4'd3, 9'd9, 1'b1, rand_data(), '0, acc);
    applyStimulus(1'b1, 3'd7, 4'd0, 9'd9, 1'b0, '0, '0, acc);
    idle(3);
    checkOutput("err_sel after sel 7", DW'(err_sel), DW'(1'b1));

    $display("[TB] reset between accept and return");
    applyStimulus(1'b1, 3'd2, 4'd0, 9'd5, 1'b0, '0, '0, acc);
    resetDut();
    idle(4);

    $display("[TB] randomized traffic");
    acc = 1'b1;
    r = 1'b0; rs = '0; rm = '0; ra = '0; rw = 1'b0; rd = '0;
    for (int n = 0; n < 400; n++) begin
      if (acc) begin
        r  = $urandom_range(0, 3) != 0;
        rs = ($urandom_range(0, 15) == 0) ? 3'd7 : 3'($urandom_range(0, NUM_PROC - 1));
        rm = 4'($urandom_range(0, 3));
        ra = AW'($urandom_range(0, 7));
        rw = $urandom_range(0, 2) == 0;
        rd = rand_data();
      end
      applyStimulus(r, rs, rm, ra, rw, rd,
                    ($urandom_range(0, 3) == 0) ? NUM_PROC'($urandom) : '0, acc);
      acc = acc || !r;
    end
    idle(5);
    checkOutput("reads outstanding at end", DW'(read_q.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/lift_bank_arbiter.md
# lift_bank_arbiter

Connects the single-core lift unit's BRAM request port to the seven per-processor coefficient memory banks. Decodes processor/memory select, drives the shared bank address/data bus, returns 240-bit read data (8 × 30-bit coefficients) at fixed latency, and stalls the lift unit while the target processor owns its memory. Sits directly between `lift_control_1core` and the processor memory banks.

## Interface
Parameters:
- `NUM_PROC`, 7, number of processor banks (sel 0..NUM_PROC-1 legal)
- `DW`, 240, data width (8 × 30-bit coefficients)
- `AW`, 9, bank address width

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: computation clock
- `rst` in 1: async reset, active high
- `lift_req` in 1: lift request valid
- `processor_sel` in 3: target processor bank
- `memory_sel` in 4: memory within bank (MemR0/MemR1/MemW0/MemW1 encoding)
- `bram_address` in AW: word address 0-511
- `bram_we` in 1: 1 = write, 0 = read
- `lift_data_out` in DW: write data from lift
- `lift_stall` out 1: request not accepted this cycle
- `lift_data_in` out DW: read data to lift
- `lift_rvalid` out 1: `lift_data_in` valid, one-cycle pulse
- `proc_busy` in NUM_PROC: processor i owns bank i
- `bank_en` out NUM_PROC: bank access strobe
- `bank_we` out NUM_PROC: bank write strobe
- `bank_mem_sel` out 4, `bank_addr` out AW, `bank_wdata` out DW: shared bank bus
- `bank_rdata` in NUM_PROC*DW: bank i read data at [i*DW +: DW], valid one cycle after `bank_en[i]`
- `err_sel` out 1: sticky illegal-select flag
- `stall_count` out 16: saturating stall-cycle counter

## Operation
- Accept = `lift_req & ~lift_stall`.
- `lift_stall` (combinational) = `lift_req & proc_busy[processor_sel]` for legal sel; 0 for illegal sel.
- Stage 1 (registered, edge after accept): `bank_en[sel]`=1, `bank_we[sel]`=`bram_we`, `bank_addr`, `bank_mem_sel`, `bank_wdata` latched; all other `bank_en`/`bank_we` = 0. No accept → all strobes 0, bus holds.
- Stage 2 (read only): at next edge capture `bank_rdata[sel]` into `lift_data_in`, pulse `lift_rvalid`. Writes produce no `lift_rvalid`.
- Back-to-back accepts every cycle supported; sel and read flag piped alongside for correct slice selection.
- Illegal sel (≥ NUM_PROC): request consumed, no bank strobe, no `lift_rvalid`, `err_sel` set until reset.
- `stall_count` +1 each cycle `lift_stall`=1, saturates at 16'hFFFF.
- `proc_busy` only gates acceptance; an already-issued stage-1 access completes even if busy rises.

## Timing
- Reset values: `bank_en`=0, `bank_we`=0, `bank_addr`=0, `bank_mem_sel`=0, `bank_wdata`=0, `lift_data_in`=0, `lift_rvalid`=0, `err_sel`=0, `stall_count`=0.
- Read latency: accept at edge E0 → bank strobe E0..E1 → `lift_data_in`/`lift_rvalid` valid after E2 (2 cycles).
- Write: bank write occurs on edge E1.
- `lift_data_in` holds last read value when `lift_rvalid`=0.
- Reset mid-pipeline: in-flight accesses dropped, no `lift_rvalid` after deassertion.
- Stall with `lift_req` held: lift must keep all request fields stable until accepted.

## Configuration
- `LIFT_ARB_BROADCAST_EN` defined: write with `processor_sel`=7 is broadcast — stage 1 asserts `bank_en`/`bank_we` on all NUM_PROC banks; stalls while any `proc_busy` bit is 1; read with sel 7 is illegal (`err_sel`).
- Undefined: sel 7 always illegal, as per Operation.

## Test plan
- Read sel=0, mem_sel=0, addr=1, bank 0 returns 8×619584084 → `lift_rvalid` pulse 2 cycles after accept with that data; only `bank_en[0]` high.
- Back-to-back reads sel=0..6 alternating addr parity → seven consecutive `lift_rvalid` pulses, each slice from the matching bank, in order.
- Write sel=3, mem_sel=2, data=8×102873779 → `bank_we[3]`=1 for one cycle, `bank_wdata` correct, no `lift_rvalid`.
- `proc_busy[5]`=1 for 4 cycles with request to sel=5 → `lift_stall` 4 cycles, `stall_count`=4, then access issues.
- sel=7 without macro → no strobes, `err_sel`=1; with macro, write sel=7 → all 7 `bank_we` high.
- Assert `rst` between accept and return → no `lift_rvalid`, all outputs at reset values.
